// File: rtl/vx_execute_pkt_arb.sv
// Packet-atomic round-robin arbiter feeding one execute-unit port from NUM_INPUTS
// issue slices, with a registered full-throughput output stage.
module vx_execute_pkt_arb #(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 64,
  parameter int SEL_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*DATAW-1:0] in_data,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic                        out_valid,
  output logic [DATAW-1:0]            out_data,
  input  logic                        out_ready,
  output logic [SEL_W-1:0]            out_sel
);

  localparam logic ST_UNLOCKED = 1'b0;
  localparam logic ST_LOCKED   = 1'b1;

  logic             state_q, state_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q;
  logic [DATAW-1:0] out_data_q;
  logic [SEL_W-1:0] out_sel_q;

  logic [SEL_W-1:0] grant;
  logic [DATAW-1:0] slice_data [NUM_INPUTS];
  logic [DATAW-1:0] beat;
  logic             en;
  logic             xfer;
  logic             beat_sop;
  logic             beat_eop;

  assign en = ~out_valid_q | out_ready;

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_slice
      assign slice_data[gi] = in_data[gi*DATAW +: DATAW];
      assign in_ready[gi]   = ~reset & en & in_valid[gi] & (grant == SEL_W'(gi));
    end
  endgenerate

  // A held lock keeps the grant even while the owner has no valid beat.
  always_comb begin
    grant = rr_ptr_q;
    if (state_q == ST_LOCKED) begin
      grant = lock_idx_q;
    end else begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        if (in_valid[(int'(rr_ptr_q) + k) % NUM_INPUTS]) begin
          grant = SEL_W'((int'(rr_ptr_q) + k) % NUM_INPUTS);
        end
      end
    end
  end

  assign beat     = slice_data[grant];
  assign xfer     = |in_ready;
  assign beat_sop = beat[1];
  assign beat_eop = beat[0];

  // A non-eop beat accepted while unlocked opens a packet, even without sop.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (xfer) begin
      if (beat_eop) begin
        state_d  = ST_UNLOCKED;
        rr_ptr_d = (grant == SEL_W'(NUM_INPUTS - 1)) ? '0 : grant + SEL_W'(1);
      end else if (state_q == ST_UNLOCKED) begin
        state_d    = ST_LOCKED;
        lock_idx_d = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_UNLOCKED;
      lock_idx_q  <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= beat;
        out_sel_q   <= grant;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

  a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0(in_ready));
  a_unlocked_sop: assert property (@(posedge clk) disable iff (reset)
    !(xfer && state_q == ST_UNLOCKED && !beat_sop));
  a_locked_no_sop: assert property (@(posedge clk) disable iff (reset)
    !(xfer && state_q == ST_LOCKED && beat_sop));

endmodule

// File: tb/tb_vx_execute_pkt_arb.sv
// Bench for vx_execute_pkt_arb: cycle tables for the directed corner cases, then
// random packet traffic checked by a per-slice in-order scoreboard.
module tb_vx_execute_pkt_arb;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int GEN = 8192;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic [1:0]      out_sel;

  vx_execute_pkt_arb #(.NUM_INPUTS(N), .DATAW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [7:0] se;   // slice i: {sop,eop} at [2i+1:2i]
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] sel;
  } vec_t;

  vec_t vecs [30];
  int total = 0;
  int bad   = 0;

  logic [DW-1:0] gen [N][GEN];
  int drv_idx [N];
  int exp_idx [N];
  int got [N];
  int owner, outs, cyc;
  logic [DW-1:0] last_data;

  function automatic vec_t mkv(input logic rst, input logic [3:0] vld, input logic [7:0] se,
                               input logic ordy, input logic [3:0] rdy, input logic ov,
                               input logic [1:0] sel);
    vec_t v;
    v.rst = rst; v.vld = vld; v.se = se; v.ordy = ordy;
    v.rdy = rdy; v.ov = ov; v.sel = sel;
    return v;
  endfunction

  function automatic logic [DW-1:0] mk_data(input int s, input int r, input logic [1:0] se2);
    return {8'(s), 8'(r), 46'd0, se2};
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, want);
    end
  endtask

  initial begin
    // Test 1: all single-beat, round robin 0,1,2,3,0
    vecs[0]  = mkv(1, 4'h0, 8'h00, 1, 4'h0, 0, 0);
    vecs[1]  = mkv(0, 4'hF, 8'hFF, 1, 4'h1, 1, 0);
    vecs[2]  = mkv(0, 4'hF, 8'hFF, 1, 4'h2, 1, 1);
    vecs[3]  = mkv(0, 4'hF, 8'hFF, 1, 4'h4, 1, 2);
    vecs[4]  = mkv(0, 4'hF, 8'hFF, 1, 4'h8, 1, 3);
    vecs[5]  = mkv(0, 4'hF, 8'hFF, 1, 4'h1, 1, 0);
    // Test 2: 3-beat packet on slice 2, then slice 3
    vecs[6]  = mkv(1, 4'h0, 8'h00, 1, 4'h0, 0, 0);
    vecs[7]  = mkv(0, 4'h4, 8'h20, 1, 4'h4, 1, 2);
    vecs[8]  = mkv(0, 4'hF, 8'hCF, 1, 4'h4, 1, 2);
    vecs[9]  = mkv(0, 4'hF, 8'hDF, 1, 4'h4, 1, 2);
    vecs[10] = mkv(0, 4'hB, 8'hFF, 1, 4'h8, 1, 3);
    // Test 3: slice 1 locked, drops valid for 2 cycles
    vecs[11] = mkv(1, 4'h0, 8'h00, 1, 4'h0, 0, 0);
    vecs[12] = mkv(0, 4'h2, 8'h08, 1, 4'h2, 1, 1);
    vecs[13] = mkv(0, 4'hD, 8'hF3, 1, 4'h0, 0, 0);
    vecs[14] = mkv(0, 4'hD, 8'hF3, 1, 4'h0, 0, 0);
    vecs[15] = mkv(0, 4'hF, 8'hF7, 1, 4'h2, 1, 1);
    vecs[16] = mkv(0, 4'hD, 8'hFF, 1, 4'h4, 1, 2);
    // Test 4: out_ready low for 5 cycles with a beat held
    vecs[17] = mkv(1, 4'h0, 8'h00, 1, 4'h0, 0, 0);
    vecs[18] = mkv(0, 4'h1, 8'hFF, 1, 4'h1, 1, 0);
    for (int i = 19; i < 24; i++) vecs[i] = mkv(0, 4'hF, 8'hFF, 0, 4'h0, 1, 0);
    vecs[24] = mkv(0, 4'hF, 8'hFF, 1, 4'h2, 1, 1);
    vecs[25] = mkv(0, 4'h0, 8'hFF, 1, 4'h0, 0, 0);
    // Test 5: reset while locked on slice 0
    vecs[26] = mkv(1, 4'h0, 8'h00, 1, 4'h0, 0, 0);
    vecs[27] = mkv(0, 4'h1, 8'h02, 1, 4'h1, 1, 0);
    vecs[28] = mkv(1, 4'h1, 8'h02, 1, 4'h0, 0, 0);
    vecs[29] = mkv(0, 4'h8, 8'hC0, 1, 4'h8, 1, 3);

    reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
    last_data = '0;

    for (int r = 0; r < 30; r++) begin
      @(negedge clk);
      reset     = vecs[r].rst;
      in_valid  = vecs[r].vld;
      out_ready = vecs[r].ordy;
      for (int s = 0; s < N; s++) in_data[s*DW +: DW] = mk_data(s, r, vecs[r].se[2*s +: 2]);
      #1;
      chk("in_ready", r, 64'(in_ready), 64'(vecs[r].rdy));
      if (vecs[r].rst) last_data = '0;
      else if (vecs[r].rdy != 0)
        last_data = mk_data(int'(vecs[r].sel), r, vecs[r].se[2*vecs[r].sel +: 2]);
      @(posedge clk);
      #1;
      chk("out_valid", r, 64'(out_valid), 64'(vecs[r].ov));
      if (vecs[r].ov) chk("out_sel", r, 64'(out_sel), 64'(vecs[r].sel));
      if (vecs[r].ov || vecs[r].rst) chk("out_data", r, out_data, last_data);
      $display("vec row=%0d rdy=%b ov=%b sel=%0d", r, in_ready, out_valid, out_sel);
    end

    // Test 6: random packet traffic against per-slice generated streams
    for (int s = 0; s < N; s++) begin
      int k;
      k = 0;
      while (k < GEN) begin
        int len;
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len && k < GEN; b++) begin
          gen[s][k] = {2'(s), 14'd0, 32'(k), 14'd0, (b == 0), (b == len - 1)};
          k++;
        end
      end
      drv_idx[s] = 0; exp_idx[s] = 0; got[s] = 0;
    end
    @(negedge clk);
    reset = 1'b1; in_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    owner = -1; outs = 0; cyc = 0;
    while (outs < 10000 && cyc < 60000) begin
      @(negedge clk);
      for (int s = 0; s < N; s++) begin
        if (drv_idx[s] < GEN) begin
          in_valid[s] = ($urandom % 10) < 7;
          in_data[s*DW +: DW] = gen[s][drv_idx[s]];
        end else begin
          in_valid[s] = 1'b0;
          in_data[s*DW +: DW] = '0;
        end
      end
      out_ready = ($urandom % 10) < 6;
      #1;
      if (!$onehot0(in_ready) || (in_ready & ~in_valid) != 0) begin
        total++; bad++;
        $display("FAIL rnd_ready cyc=%0d got=%b valid=%b", cyc, in_ready, in_valid);
      end
      for (int s = 0; s < N; s++) if (in_ready[s]) drv_idx[s]++;
      if (out_valid && out_ready) begin
        int s;
        s = int'(out_sel);
        if (exp_idx[s] < GEN) chk("rnd_data", cyc, out_data, gen[s][exp_idx[s]]);
        if (owner >= 0) chk("rnd_interleave", cyc, 64'(s), 64'(owner));
        owner = out_data[0] ? -1 : s;
        exp_idx[s]++;
        got[s]++;
        outs++;
        if (outs % 1000 == 0)
          $display("rnd beats=%0d sel=%0d data=%h", outs, s, out_data);
      end
      cyc++;
    end
    chk("rnd_budget", cyc, 64'(outs >= 10000), 64'(1));
    for (int s = 0; s < N; s++) chk("rnd_fair", s, 64'(got[s] > 0), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
